// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, recovered word and status strobes out.
`timescale 1ns/1ps
interface uart_rx_if #(
  parameter int DATA_W = 8
);
  logic              rx_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              frame_err_o;
  logic              busy_o;

  modport master (
    input  rx_i,
    output data_o,
    output valid_o,
    output frame_err_o,
    output busy_o
  );

  modport slave (
    output rx_i,
    input  data_o,
    input  valid_o,
    input  frame_err_o,
    input  busy_o
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: mid-bit sampling, LSB first, with framing-error and
// held-low (break) detection so a stuck-low line is not decoded as repeated zeros.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master bus
);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift;
  logic              rx_meta;
  logic              rx_s;

  // Two-flop synchronizer; idle level is high so both flops reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx_i;
      rx_s    <= rx_meta;
    end
  end

  // busy_o is assigned alongside every state update so it tracks the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      bus.data_o      <= '0;
      bus.valid_o     <= 1'b0;
      bus.frame_err_o <= 1'b0;
      bus.busy_o      <= 1'b0;
    end else begin
      bus.valid_o     <= 1'b0;
      bus.frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state      <= START;
            cnt        <= '0;
            bus.busy_o <= 1'b1;
          end else begin
            bus.busy_o <= 1'b0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state      <= DATA;
              bit_idx    <= '0;
              bus.busy_o <= 1'b1;
            end else begin
              state      <= IDLE;
              bus.busy_o <= 1'b0;
            end
          end else begin
            cnt        <= cnt + 1'b1;
            bus.busy_o <= 1'b1;
          end
        end
        DATA: begin
          bus.busy_o <= 1'b1;
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[DATA_W-1:1]};
            if (bit_idx == IDX_LAST) begin
              state   <= STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              bus.data_o  <= shift;
              bus.valid_o <= 1'b1;
              state       <= IDLE;
              bus.busy_o  <= 1'b0;
            end else begin
              bus.frame_err_o <= 1'b1;
              state           <= BREAK;
              bus.busy_o      <= 1'b1;
            end
          end else begin
            cnt        <= cnt + 1'b1;
            bus.busy_o <= 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state      <= IDLE;
            bus.busy_o <= 1'b0;
          end else begin
            bus.busy_o <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          bit_idx    <= '0;
          bus.busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx, checked against a frame-level timing model.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB  = 4;
  localparam int DW   = 8;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + (DW + 1) * CPB;

  typedef struct {
    logic       kind;
    int         t;
    logic [7:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_total = 0;
  int   both_cnt = 0;
  int   obs_rd = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];

  uart_rx_if #(.DATA_W(DW)) bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) obs_q.push_back('{1'b0, cyc, bus.data_o});
    if (bus.frame_err_o === 1'b1) obs_q.push_back('{1'b1, cyc, bus.data_o});
    if (bus.valid_o === 1'b1 && bus.frame_err_o === 1'b1) both_cnt <= both_cnt + 1;
    if (bus.busy_o === 1'b1) busy_total <= busy_total + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame model: start low, DW data bits LSB first, one stop bit, CPB cycles each.
  // Returns e, the edge at which the first synchronizer flop sees the start bit.
  task automatic send(input logic [7:0] b, input logic stop, output int e);
    @(posedge clk);
    #1;
    bus.rx_i = 1'b0;
    e = cyc + 1;
    for (int i = 0; i < DW; i++) begin
      repeat (CPB) @(posedge clk);
      #1;
      bus.rx_i = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1;
    bus.rx_i = stop;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, obs_q.size() - obs_rd, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_rd + i < obs_q.size()) begin
        chk({tag, "_kind"}, {31'd0, obs_q[obs_rd + i].kind}, {31'd0, exp_q[i].kind});
        chk({tag, "_time"}, obs_q[obs_rd + i].t, exp_q[i].t);
        chk({tag, "_data"}, {24'd0, obs_q[obs_rd + i].d}, {24'd0, exp_q[i].d});
      end
    end
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  initial begin
    int e;
    int e2;
    int b0;
    logic [7:0] last_good;
    logic [7:0] rb;

    bus.rx_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {24'd0, bus.data_o}, 32'd0);
    chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("rst_ferr", {31'd0, bus.frame_err_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    b0 = busy_total;
    send(8'hA5, 1'b1, e);
    exp_q.push_back('{1'b0, e + LAT, 8'hA5});
    repeat (10) @(posedge clk);
    #1;
    check_events("a5");
    chk("a5_busy_cycles", busy_total - b0, LAT - 2);
    chk("a5_data_hold", {24'd0, bus.data_o}, 32'hA5);
    last_good = 8'hA5;

    b0 = busy_total;
    @(posedge clk);
    #1;
    bus.rx_i = 1'b0;
    @(posedge clk);
    #1;
    bus.rx_i = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("glitch_busy_cycles", busy_total - b0, HALF);
    check_events("glitch");
    chk("glitch_data", {24'd0, bus.data_o}, {24'd0, last_good});

    send(8'h3C, 1'b0, e);
    exp_q.push_back('{1'b1, e + LAT, last_good});
    repeat (20) @(posedge clk);
    #1;
    chk("break_busy_high", {31'd0, bus.busy_o}, 32'd1);
    bus.rx_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("break_busy_low", {31'd0, bus.busy_o}, 32'd0);
    check_events("ferr");
    chk("ferr_data", {24'd0, bus.data_o}, {24'd0, last_good});

    send(8'h00, 1'b1, e);
    send(8'hFF, 1'b1, e2);
    exp_q.push_back('{1'b0, e + LAT, 8'h00});
    exp_q.push_back('{1'b0, e2 + LAT, 8'hFF});
    repeat (10) @(posedge clk);
    #1;
    chk("b2b_spacing", e2 - e, (DW + 2) * CPB);
    check_events("b2b");
    last_good = 8'hFF;

    fork
      send(8'h5A, 1'b1, e);
      begin
        repeat (18) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_data", {24'd0, bus.data_o}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("midrst_valid", {31'd0, bus.valid_o}, 32'd0);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check_events("midrst");
    send(8'h81, 1'b1, e);
    exp_q.push_back('{1'b0, e + LAT, 8'h81});
    repeat (10) @(posedge clk);
    #1;
    check_events("after_rst");

    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(rb, 1'b1, e);
      exp_q.push_back('{1'b0, e + LAT, rb});
    end
    repeat (20) @(posedge clk);
    #1;
    check_events("rand");

    chk("never_both", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
